// File: rtl/simpson_pkg.sv
// rtl/simpson_pkg.sv - shared types and constants for the Simpson's-rule scheduler
package simpson_pkg;

  localparam int W_DEF = 16;

  // Simpson weights for one pair of intervals: 1, 4, 1 over divisor 3
  localparam int WT_END  = 1;
  localparam int WT_MID  = 4;
  localparam int DIVISOR = 3;

  // Odd tail is integrated with the trapezoid rule: (v1 + v2) >> 1
  localparam int TAIL_SHIFT = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_TAIL_X1,
    S_TAIL_X2,
    S_TAIL_ACC,
    S_P_X0,
    S_P_X1,
    S_P_X2,
    S_P_ACC,
    S_FINISH
  } state_t;

endpackage

// File: rtl/simpson_if.sv
// rtl/simpson_if.sv - user-side and evaluator-side signals of the scheduler
interface simpson_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;
  logic         eval_req;
  logic [W-1:0] eval_x;
  logic         eval_ack;
  logic [W-1:0] eval_value;

  // The scheduler itself
  modport slave (
    input  start, a_in, b_in, eval_ack, eval_value,
    output busy, done, err, result, eval_req, eval_x
  );

  // The user FSM plus the evaluator
  modport master (
    output start, a_in, b_in, eval_ack, eval_value,
    input  busy, done, err, result, eval_req, eval_x
  );
endinterface

// File: rtl/simpson_acc.sv
// rtl/simpson_acc.sv - weighted-sum, divide and accumulate datapath
module simpson_acc
  import simpson_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = W + 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_add,
  input  logic         i_tail,
  input  logic [W-1:0] i_v0,
  input  logic [W-1:0] i_v1,
  input  logic [W-1:0] i_v2,
  output logic [W-1:0] o_acc
);

  logic [W:0]    w_tail_sum;
  logic [W-1:0]  w_tail_term;
  logic [SW-1:0] w_pair_sum;
  logic [W-1:0]  w_pair_term;
  logic [W-1:0]  w_inc;
  logic [W-1:0]  r_acc;

  // Tail: average of the two endpoints, one extra bit so the carry is kept
  assign w_tail_sum  = {1'b0, i_v1} + {1'b0, i_v2};
  assign w_tail_term = W'(w_tail_sum >> TAIL_SHIFT);

  // Pair: 1-4-1 weighted sum is wide enough for the worst case, then truncating divide
  assign w_pair_sum  = SW'(WT_END) * SW'(i_v0) + SW'(WT_MID) * SW'(i_v1) + SW'(WT_END) * SW'(i_v2);
  assign w_pair_term = W'(w_pair_sum / SW'(DIVISOR));

  assign w_inc = i_tail ? w_tail_term : w_pair_term;
  assign o_acc = r_acc;

  // Accumulator wraps mod 2^W; clear wins over add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + w_inc;
    end
  end

endmodule

// File: rtl/simpson_sched.sv
// rtl/simpson_sched.sv - sequences Simpson's-rule evaluations over one shared evaluator
module simpson_sched
  import simpson_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = W + 3
) (
  input  logic      clk,
  input  logic      rst_n,
  simpson_if.slave  io_bus
);

  state_t       r_state;
  logic [W-1:0] r_ra;
  logic [W-1:0] r_rb;
  logic [W-1:0] r_f0;
  logic [W-1:0] r_f1;
  logic [W-1:0] r_f2;
  logic         r_cache;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic [W-1:0] r_result;
  logic         r_req;
  logic [W-1:0] r_x;

  logic         w_hs;
  logic         w_clear;
  logic         w_add;
  logic         w_tail;
  logic [W-1:0] w_acc;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_rb_dec;
  logic [W-1:0] w_ra_inc1;
  logic [W-1:0] w_ra_inc2;

  assign w_hs      = r_req & io_bus.eval_ack;
  assign w_clear   = (r_state == S_IDLE) & io_bus.start;
  assign w_add     = (r_state == S_TAIL_ACC) | (r_state == S_P_ACC);
  assign w_tail    = (r_state == S_TAIL_ACC);
  assign w_diff    = r_rb - r_ra;
  assign w_rb_dec  = r_rb - W'(1);
  assign w_ra_inc1 = r_ra + W'(1);
  assign w_ra_inc2 = r_ra + W'(2);

  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.err      = r_err;
  assign io_bus.result   = r_result;
  assign io_bus.eval_req = r_req;
  assign io_bus.eval_x   = r_x;

  simpson_acc #(
    .W  (W),
    .SW (SW)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_add   (w_add),
    .i_tail  (w_tail),
    .i_v0    (r_f0),
    .i_v1    (r_f1),
    .i_v2    (r_f2),
    .o_acc   (w_acc)
  );

  // Control FSM: eval_req/eval_x are set on the edge entering an eval state and
  // the state is left on the edge where the handshake completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ra     <= '0;
      r_rb     <= '0;
      r_f0     <= '0;
      r_f1     <= '0;
      r_f2     <= '0;
      r_cache  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_req    <= 1'b0;
      r_x      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_ra    <= io_bus.a_in;
            r_rb    <= io_bus.b_in;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_cache <= 1'b0;
          if (r_ra >= r_rb) begin
            // Empty or reversed interval: report with a zero result
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_acc;
            r_state  <= S_FINISH;
          end else if (w_diff[0]) begin
            r_req   <= 1'b1;
            r_x     <= w_rb_dec;
            r_state <= S_TAIL_X1;
          end else begin
            r_req   <= 1'b1;
            r_x     <= r_ra;
            r_state <= S_P_X0;
          end
        end
        S_TAIL_X1: begin
          if (w_hs) begin
            r_f1    <= io_bus.eval_value;
            r_x     <= r_rb;
            r_state <= S_TAIL_X2;
          end
        end
        S_TAIL_X2: begin
          if (w_hs) begin
            r_f2    <= io_bus.eval_value;
            r_req   <= 1'b0;
            r_state <= S_TAIL_ACC;
          end
        end
        S_TAIL_ACC: begin
          // Tail consumed the last interval; the remaining span is even
          r_rb    <= w_rb_dec;
          r_cache <= 1'b0;
          r_req   <= (r_ra != w_rb_dec);
          r_x     <= r_ra;
          r_state <= S_P_X0;
        end
        S_P_X0: begin
          if (r_ra == r_rb) begin
            r_req    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_acc;
            r_state  <= S_FINISH;
          end else if (r_cache) begin
            // f0 is the previous pair's f2, so go straight to the midpoint
            r_req   <= 1'b1;
            r_x     <= w_ra_inc1;
            r_state <= S_P_X1;
          end else if (w_hs) begin
            r_f0    <= io_bus.eval_value;
            r_x     <= w_ra_inc1;
            r_state <= S_P_X1;
          end
        end
        S_P_X1: begin
          if (w_hs) begin
            r_f1    <= io_bus.eval_value;
            r_x     <= w_ra_inc2;
            r_state <= S_P_X2;
          end
        end
        S_P_X2: begin
          if (w_hs) begin
            r_f2    <= io_bus.eval_value;
            r_req   <= 1'b0;
            r_state <= S_P_ACC;
          end
        end
        S_P_ACC: begin
          r_f0    <= r_f2;
          r_cache <= 1'b1;
          r_ra    <= w_ra_inc2;
          r_state <= S_P_X0;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
